pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Consumer side of the hazard-detection stall interface: turns raw stall/flush requests into per-stage
//  write enables, bubbles and flushes for the 5-stage MIPS pipeline (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Enforces bounded load-use stalls with guaranteed forward progress, freezes the whole pipe on data-memory
//  wait with timeout, and applies branch flushes. Sits between hazard unit/branch logic/dmem and pipe regs.
// PARAMETERS
//  LU_STALL_CYCLES  1    cycles of PC/IF-ID hold + ID/EX bubble per load-use hazard (1..3)
//  MEM_TIMEOUT      255  max cycles in memory wait before abort (8-bit counter)
//  PERF_W           32   width of performance counters (STALL_PERF_EN only)
// PORTS
//  clk_i            in   1       clock, all state on rising edge
//  rst_i            in   1       synchronous reset, active-high
//  hazard_stall_i   in   1       load-use request from hazard detection (may stay high; level, not pulse)
//  branch_taken_i   in   1       branch/jump resolved taken in ID; IF/ID must be flushed
//  mem_stall_req_i  in   1       data memory busy, freeze pipe
//  mem_ready_i      in   1       data memory completed access
//  pc_we_o          out  1       PC write enable
//  if_id_we_o       out  1       IF/ID write enable
//  if_id_flush_o    out  1       IF/ID load NOP
//  id_ex_bubble_o   out  1       ID/EX load control zeros
//  pipe_we_o        out  1       ID/EX, EX/MEM, MEM/WB write enable
//  state_o          out  2       current FSM state (debug)
//  timeout_o        out  1       sticky: memory wait exceeded MEM_TIMEOUT
//  lu_cnt_o         out  PERF_W  load-use stall cycles
//  mem_cnt_o        out  PERF_W  memory wait cycles
//  flush_cnt_o      out  PERF_W  branch flushes
// BEHAVIOUR
//  Outputs combinational from state+inputs; rst_i high forces all *_we_o=0, flush/bubble=0 same cycle.
//  Reset: state=RUN, counters=0, timeout_o=0, lu_cnt=0; post-reset outputs per RUN.
//  States: RUN=0, LU_STALL=1, LU_ADV=2, MEM_WAIT=3.
//  Priority each cycle: mem_stall_req_i > hazard_stall_i > branch_taken_i.
//  RUN: all we=1, no flush/bubble, unless:
//   mem_stall_req_i -> all we=0, no bubble/flush; next MEM_WAIT, tmo_cnt=0.
//   hazard_stall_i -> pc_we=0, if_id_we=0, id_ex_bubble=1, pipe_we=1; next LU_STALL if LU_STALL_CYCLES>1
//    (lu_cnt=1) else LU_ADV. branch_taken_i ignored this cycle (re-evaluated after stall).
//   branch_taken_i -> if_id_flush=1, pc_we=1 (target), other we=1.
//  LU_STALL: same outputs as load-use stall; lu_cnt++; at lu_cnt==LU_STALL_CYCLES-1 -> LU_ADV.
//  LU_ADV: hazard_stall_i ignored (forward progress); branch_taken_i honoured; all we=1; -> RUN.
//  MEM_WAIT: all we=0, no bubble/flush; branch and hazard ignored. mem_ready_i -> return state
//   (RUN, or suspended LU_STALL/LU_ADV with lu_cnt frozen); tmo_cnt==MEM_TIMEOUT w/o ready ->
//   timeout_o=1 (sticky until reset), -> RUN. mem_ready_i and timeout same cycle: ready wins.
//  mem_stall_req_i in LU_STALL/LU_ADV: freeze as MEM_WAIT, remember return state (2-bit reg).
//  mem_ready_i outside MEM_WAIT ignored. Reset mid-wait/stall: state RUN, return state cleared.
// CONFIGURATION
//  STALL_PERF_EN defined: lu_cnt_o/mem_cnt_o/flush_cnt_o count cycles in LU stall, MEM_WAIT, and
//   asserted if_id_flush_o; saturate at all-ones; cleared by rst_i.
//  Undefined: the three outputs tied to 0, no counter flops.
// STRUCTURE
//  Shared defs (stall_ctrl_defs.vh): state encodings ST_RUN/ST_LU_STALL/ST_LU_ADV/ST_MEM_WAIT, control
//   bit layout shared with the pipe-register modules.
//  Sub-module stall_perf_cnt (one saturating PERF_W counter with inc/clr), instanced 3x under STALL_PERF_EN.
// TESTING
//  1 reset: rst_i=1 two cycles -> all we=0, state_o=0, timeout_o=0; release -> pc_we=if_id_we=pipe_we=1.
//  2 load-use, hazard_stall_i held high 5 cycles, LU_STALL_CYCLES=1 -> pc_we=0/bubble=1 on cycle 1,
//    cycle 2 all we=1 (LU_ADV), cycle 3 stalls again; alternates, never two consecutive stalls.
//  3 hazard_stall_i+branch_taken_i same cycle -> stall, no flush; next cycle branch high -> if_id_flush=1.
//  4 mem_stall_req_i 1 cycle, mem_ready_i after 10 -> 11 cycles all we=0, state_o=3; then RUN;
//    mem_cnt_o=11 with STALL_PERF_EN.
//  5 mem wait, no ready, MEM_TIMEOUT=4 -> timeout_o=1 after 5th wait cycle, state RUN, stays 1 until rst_i.
//  6 mem_stall_req_i during LU_STALL (LU_STALL_CYCLES=3, lu_cnt=1) -> freeze; after ready, 1 more
//    stall cycle then LU_ADV; rst_i mid-wait -> state_o=0 next cycle.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM state encodings
// and the per-stage control bit layout used by the pipe-register modules.
package pipe_stall_ctrl_pkg;

    // FSM states, encoded to match the 2-bit debug state output
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_LU_ADV   = 2'd2,
        ST_MEM_WAIT = 2'd3
    } stall_state_e;

    // Control bundle driven to the PC and the pipeline registers
    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_we;
    } stall_ctrl_t;

    // Normal flow: every stage advances
    localparam stall_ctrl_t CTRL_RUN    = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                            id_ex_bubble: 1'b0, pipe_we: 1'b1};
    // Whole pipe frozen while data memory is busy
    localparam stall_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                            id_ex_bubble: 1'b0, pipe_we: 1'b0};
    // Load-use stall: hold PC and IF/ID, inject a bubble into ID/EX
    localparam stall_ctrl_t CTRL_LU     = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                            id_ex_bubble: 1'b1, pipe_we: 1'b1};
    // Taken branch: PC loads the target, IF/ID is replaced by a NOP
    localparam stall_ctrl_t CTRL_FLUSH  = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                            id_ex_bubble: 1'b0, pipe_we: 1'b1};

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating performance counter with synchronous clear, used three times by
// the stall controller when STALL_PERF_EN is defined.
module stall_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt;

    // Count qualifying cycles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt <= '0;
        end else if (inc_i && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign cnt_o = cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: converts load-use, memory-busy and taken-branch
// requests into PC / pipe-register write enables, bubbles and flushes.
// Optional feature macro: STALL_PERF_EN adds saturating performance counters.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned PERF_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hazard_stall_i,
    input  logic              branch_taken_i,
    input  logic              mem_stall_req_i,
    input  logic              mem_ready_i,
    output logic              pc_we_o,
    output logic              if_id_we_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic              pipe_we_o,
    output logic [1:0]        state_o,
    output logic              timeout_o,
    output logic [PERF_W-1:0] lu_cnt_o,
    output logic [PERF_W-1:0] mem_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o
);

    localparam logic [1:0] LU_LAST  = 2'(LU_STALL_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT);

    stall_state_e state, state_n;
    stall_state_e ret_state, ret_state_n;
    logic [1:0]   lu_cnt, lu_cnt_n;
    logic [7:0]   tmo_cnt, tmo_cnt_n;
    logic         timeout_q, timeout_n;
    stall_ctrl_t  ctrl_raw;
    stall_ctrl_t  ctrl;

    // State, return-state, stall/timeout counters and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            lu_cnt    <= '0;
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            ret_state <= ret_state_n;
            lu_cnt    <= lu_cnt_n;
            tmo_cnt   <= tmo_cnt_n;
            timeout_q <= timeout_n;
        end
    end

    // Next-state and control decode; memory beats load-use beats branch
    always_comb begin
        state_n     = state;
        ret_state_n = ret_state;
        lu_cnt_n    = lu_cnt;
        tmo_cnt_n   = tmo_cnt;
        timeout_n   = timeout_q;
        ctrl_raw    = CTRL_RUN;

        unique case (state)
            ST_RUN: begin
                if (mem_stall_req_i) begin
                    ctrl_raw    = CTRL_FREEZE;
                    state_n     = ST_MEM_WAIT;
                    ret_state_n = ST_RUN;
                    tmo_cnt_n   = '0;
                end else if (hazard_stall_i) begin
                    ctrl_raw = CTRL_LU;
                    if (LU_STALL_CYCLES > 1) begin
                        state_n  = ST_LU_STALL;
                        lu_cnt_n = 2'd1;
                    end else begin
                        state_n = ST_LU_ADV;
                    end
                end else if (branch_taken_i) begin
                    ctrl_raw = CTRL_FLUSH;
                end
            end

            ST_LU_STALL: begin
                if (mem_stall_req_i) begin
                    ctrl_raw    = CTRL_FREEZE;
                    state_n     = ST_MEM_WAIT;
                    ret_state_n = ST_LU_STALL;
                    tmo_cnt_n   = '0;
                end else begin
                    ctrl_raw = CTRL_LU;
                    if (lu_cnt == LU_LAST) begin
                        state_n = ST_LU_ADV;
                    end else begin
                        lu_cnt_n = lu_cnt + 2'd1;
                    end
                end
            end

            ST_LU_ADV: begin
                if (mem_stall_req_i) begin
                    ctrl_raw    = CTRL_FREEZE;
                    state_n     = ST_MEM_WAIT;
                    ret_state_n = ST_LU_ADV;
                    tmo_cnt_n   = '0;
                end else begin
                    state_n = ST_RUN;
                    if (branch_taken_i) begin
                        ctrl_raw = CTRL_FLUSH;
                    end
                end
            end

            ST_MEM_WAIT: begin
                ctrl_raw = CTRL_FREEZE;
                if (mem_ready_i) begin
                    state_n = ret_state;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = ST_RUN;
                end else begin
                    tmo_cnt_n = tmo_cnt + 8'd1;
                end
            end

            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    // Reset forces every enable, flush and bubble low in the same cycle
    always_comb begin
        ctrl = ctrl_raw;
        if (rst_i) begin
            ctrl = CTRL_FREEZE;
        end
    end

    assign pc_we_o        = ctrl.pc_we;
    assign if_id_we_o     = ctrl.if_id_we;
    assign if_id_flush_o  = ctrl.if_id_flush;
    assign id_ex_bubble_o = ctrl.id_ex_bubble;
    assign pipe_we_o      = ctrl.pipe_we;
    assign state_o        = state;
    assign timeout_o      = timeout_q;

`ifdef STALL_PERF_EN
    logic lu_inc;
    logic mem_inc;
    logic flush_inc;

    assign lu_inc    = ctrl.id_ex_bubble;
    assign mem_inc   = !rst_i && (ctrl_raw == CTRL_FREEZE);
    assign flush_inc = ctrl.if_id_flush;

    stall_perf_cnt #(.W(PERF_W)) u_lu_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (lu_inc),
        .cnt_o (lu_cnt_o)
    );

    stall_perf_cnt #(.W(PERF_W)) u_mem_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (mem_inc),
        .cnt_o (mem_cnt_o)
    );

    stall_perf_cnt #(.W(PERF_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (flush_inc),
        .cnt_o (flush_cnt_o)
    );
`else
    assign lu_cnt_o    = '0;
    assign mem_cnt_o   = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl. Two instances share the stimulus:
// dut_a (1 load-use cycle, long memory timeout) and dut_b (3 load-use cycles,
// memory timeout of 4); each expected entry names the instance it checks.
module tb_pipe_stall_ctrl;

    localparam logic [4:0] RUNV = 5'b11001;
    localparam logic [4:0] FRZ  = 5'b00000;
    localparam logic [4:0] LUV  = 5'b00011;
    localparam logic [4:0] FLV  = 5'b11101;

    typedef struct packed {
        logic       sel;
        logic [4:0] ctrl;
        logic [1:0] st;
        logic       tmo;
    } exp_t;

    logic clk_i;
    logic rst_i;
    logic hazard_stall_i;
    logic branch_taken_i;
    logic mem_stall_req_i;
    logic mem_ready_i;

    logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_bubble, a_pipe_we, a_timeout;
    logic [1:0]  a_state;
    logic [31:0] a_lu_cnt, a_mem_cnt, a_flush_cnt;
    logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_bubble, b_pipe_we, b_timeout;
    logic [1:0]  b_state;
    logic [31:0] b_lu_cnt, b_mem_cnt, b_flush_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    pipe_stall_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(255), .PERF_W(32)) dut_a (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hazard_stall_i  (hazard_stall_i),
        .branch_taken_i  (branch_taken_i),
        .mem_stall_req_i (mem_stall_req_i),
        .mem_ready_i     (mem_ready_i),
        .pc_we_o         (a_pc_we),
        .if_id_we_o      (a_if_id_we),
        .if_id_flush_o   (a_if_id_flush),
        .id_ex_bubble_o  (a_id_ex_bubble),
        .pipe_we_o       (a_pipe_we),
        .state_o         (a_state),
        .timeout_o       (a_timeout),
        .lu_cnt_o        (a_lu_cnt),
        .mem_cnt_o       (a_mem_cnt),
        .flush_cnt_o     (a_flush_cnt)
    );

    pipe_stall_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(4), .PERF_W(32)) dut_b (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .hazard_stall_i  (hazard_stall_i),
        .branch_taken_i  (branch_taken_i),
        .mem_stall_req_i (mem_stall_req_i),
        .mem_ready_i     (mem_ready_i),
        .pc_we_o         (b_pc_we),
        .if_id_we_o      (b_if_id_we),
        .if_id_flush_o   (b_if_id_flush),
        .id_ex_bubble_o  (b_id_ex_bubble),
        .pipe_we_o       (b_pipe_we),
        .state_o         (b_state),
        .timeout_o       (b_timeout),
        .lu_cnt_o        (b_lu_cnt),
        .mem_cnt_o       (b_mem_cnt),
        .flush_cnt_o     (b_flush_cnt)
    );

    // Free-running clock, period 10
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Drive one cycle of inputs just after the rising edge and queue the expected outputs
    task automatic applyStimulus(input logic r, input logic h, input logic b, input logic mq,
                                 input logic mr, input logic sel, input logic [4:0] ectrl,
                                 input logic [1:0] est, input logic etmo, input string nm);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_i           = r;
        hazard_stall_i  = h;
        branch_taken_i  = b;
        mem_stall_req_i = mq;
        mem_ready_i     = mr;
        e.sel  = sel;
        e.ctrl = ectrl;
        e.st   = est;
        e.tmo  = etmo;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Compare one observed value with its required value
    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Monitor: on each falling edge pop the queued expectation and compare the chosen instance
    initial begin
        exp_t       e;
        string      nm;
        logic [8:0] act;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.sel) begin
                    act = {b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_bubble, b_pipe_we,
                           b_state, b_timeout, 1'b0};
                end else begin
                    act = {a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_bubble, a_pipe_we,
                           a_state, a_timeout, 1'b0};
                end
                checkOutput(nm, {23'd0, act}, {23'd0, e.ctrl, e.st, e.tmo, 1'b0});
            end
        end
    end

    // Directed scenarios
    initial begin
        int wait_cycles;
        rst_i           = 1'b1;
        hazard_stall_i  = 1'b0;
        branch_taken_i  = 1'b0;
        mem_stall_req_i = 1'b0;
        mem_ready_i     = 1'b0;

        // reset held two cycles, then release
        applyStimulus(1, 0, 0, 0, 0, 0, FRZ,  2'd0, 0, "rst0");
        applyStimulus(1, 0, 0, 0, 0, 0, FRZ,  2'd0, 0, "rst1");
        applyStimulus(0, 0, 0, 0, 0, 0, RUNV, 2'd0, 0, "rst_release");

        // load-use held high: stall and advance alternate
        applyStimulus(0, 1, 0, 0, 0, 0, LUV,  2'd0, 0, "lu_c1");
        applyStimulus(0, 1, 0, 0, 0, 0, RUNV, 2'd2, 0, "lu_c2");
        applyStimulus(0, 1, 0, 0, 0, 0, LUV,  2'd0, 0, "lu_c3");
        applyStimulus(0, 1, 0, 0, 0, 0, RUNV, 2'd2, 0, "lu_c4");
        applyStimulus(0, 1, 0, 0, 0, 0, LUV,  2'd0, 0, "lu_c5");
        applyStimulus(0, 0, 0, 0, 0, 0, RUNV, 2'd2, 0, "lu_adv_end");
        applyStimulus(0, 0, 0, 0, 0, 0, RUNV, 2'd0, 0, "lu_idle");

        // hazard and branch together: stall first, flush next cycle
        applyStimulus(0, 1, 1, 0, 0, 0, LUV,  2'd0, 0, "hb_stall");
        applyStimulus(0, 0, 1, 0, 0, 0, FLV,  2'd2, 0, "hb_flush");
        applyStimulus(0, 0, 0, 0, 0, 0, RUNV, 2'd0, 0, "hb_idle");

        // memory freeze: one request cycle, nine waits, ready on the eleventh frozen cycle
        applyStimulus(0, 0, 0, 1, 0, 0, FRZ,  2'd0, 0, "mem_req");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 0, FRZ, 2'd3, 0, "mem_wait");
        end
        applyStimulus(0, 0, 0, 0, 1, 0, FRZ,  2'd3, 0, "mem_ready");
        applyStimulus(0, 0, 0, 0, 0, 0, RUNV, 2'd0, 0, "mem_back_run");
`ifdef STALL_PERF_EN
        checkOutput("perf_mem_cnt", a_mem_cnt, 32'd11);
`else
        checkOutput("perf_lu_zero",    a_lu_cnt,    32'd0);
        checkOutput("perf_mem_zero",   a_mem_cnt,   32'd0);
        checkOutput("perf_flush_zero", a_flush_cnt, 32'd0);
`endif

        // memory timeout on dut_b (limit 4): five waits then sticky timeout
        applyStimulus(1, 0, 0, 0, 0, 1, FRZ,  2'd0, 1, "tmo_rst");
        applyStimulus(0, 0, 0, 1, 0, 1, FRZ,  2'd0, 0, "tmo_req");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, FRZ, 2'd3, 0, "tmo_wait");
        end
        applyStimulus(0, 0, 0, 0, 0, 1, RUNV, 2'd0, 1, "tmo_set");
        applyStimulus(0, 0, 0, 0, 1, 1, RUNV, 2'd0, 1, "tmo_sticky");
        applyStimulus(1, 0, 0, 0, 0, 1, FRZ,  2'd0, 1, "tmo_rst_cycle");
        applyStimulus(0, 0, 0, 0, 0, 1, RUNV, 2'd0, 0, "tmo_cleared");

        // memory request after two load-use stall cycles on dut_b, then resume
        applyStimulus(0, 1, 0, 0, 0, 1, LUV,  2'd0, 0, "lum_stall1");
        applyStimulus(0, 1, 0, 0, 0, 1, LUV,  2'd1, 0, "lum_stall2");
        applyStimulus(0, 1, 0, 1, 0, 1, FRZ,  2'd1, 0, "lum_freeze");
        applyStimulus(0, 1, 0, 0, 0, 1, FRZ,  2'd3, 0, "lum_wait");
        applyStimulus(0, 1, 0, 0, 1, 1, FRZ,  2'd3, 0, "lum_ready");
        applyStimulus(0, 1, 0, 0, 0, 1, LUV,  2'd1, 0, "lum_last_stall");
        applyStimulus(0, 1, 0, 0, 0, 1, RUNV, 2'd2, 0, "lum_adv");
        applyStimulus(0, 0, 0, 0, 0, 1, RUNV, 2'd0, 0, "lum_run");

        // reset in the middle of a memory wait
        applyStimulus(0, 0, 0, 1, 0, 1, FRZ,  2'd0, 0, "rmw_req");
        applyStimulus(0, 0, 0, 0, 0, 1, FRZ,  2'd3, 0, "rmw_wait");
        applyStimulus(1, 0, 0, 0, 0, 1, FRZ,  2'd3, 0, "rmw_rst");
        applyStimulus(0, 0, 0, 0, 1, 1, RUNV, 2'd0, 0, "rmw_after");

        // let the monitor drain the queue, bounded
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clk_i);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain actual=%0d required=0 entries left", exp_q.size());
        end
        @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
